// File: rtl/uart_frame_ctrl.sv
// Purpose : UART RX frame controller. It parses HEADER, LEN, payload and CSUM, and buffers the payload.
//           The payload is released only after the checksum passes.
// Latency : out_valid rises 1 cycle after the rx_done that carries a good checksum. Drain runs at 1 byte/cycle.
// Backpr. : out_data/out_valid/out_last hold while out_valid && !out_ready. Bytes arriving during drain are dropped.
//
// Ports: clk/rst (async, active-high); rx_data/rx_done byte stream in;
//        out_data/out_valid/out_ready/out_last payload stream out; frame_len length of frame being drained;
//        frame_err one-cycle error pulse with err_code (01 length, 10 checksum, 11 timeout);
//        stat_ok/stat_bad saturating frame counters, present only when UART_FRAME_STATS_EN is defined (else 0).
module uart_frame_ctrl #(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         BAUD          = 9600,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_done,
    output logic [7:0]                   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    output logic                         frame_err,
    output logic [1:0]                   err_code,
    output logic [15:0]                  stat_ok,
    output logic [15:0]                  stat_bad
);
    localparam int         LW       = $clog2(MAX_LEN + 1);
    localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // The product is computed in 64 bits so that large clock rates cannot overflow it.
    localparam longint     TO_L     = longint'(TIMEOUT_BYTES) * 10 * longint'(CLK_FREQ) / longint'(BAUD);
    localparam int         TO_CYC   = (TO_L < 1) ? 1 : int'(TO_L);
    localparam int         TW       = $clog2(TO_CYC + 1);
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_t;

    state_t        state;
    logic [7:0]    pay_buf [2**AW];
    logic [AW-1:0] idx;
    logic [AW-1:0] rd;
    logic [LW-1:0] len;
    logic [7:0]    sum;
    logic [TW-1:0] tmr;

    logic [7:0]    sum_next;
    logic          active;
    logic          tmr_exp;
    logic          len_bad;
    logic [AW-1:0] rd_nxt;

    assign sum_next = sum + rx_data;
    assign active   = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    // Expiry is the Nth cycle without a byte. A byte in that same cycle takes precedence.
    assign tmr_exp  = active && !rx_done && (tmr == TW'(TO_CYC - 1));
    assign len_bad  = (rx_data == 8'd0) || (rx_data > MAX_LEN8);
    assign rd_nxt   = rd + 1'b1;

    // The payload store has no reset because its contents only matter after a full frame has been written.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && rx_done)
            pay_buf[idx] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            rd        <= '0;
            len       <= '0;
            sum       <= '0;
            tmr       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_len <= '0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            frame_err <= 1'b0;

            if (!active || rx_done)
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;

            case (state)
                IDLE: begin
                    if (rx_done && rx_data == HEADER)
                        state <= LEN;
                end
                LEN: begin
                    if (rx_done) begin
                        if (len_bad) begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                            err_code  <= 2'b01;
                        end else begin
                            len   <= rx_data[LW-1:0];
                            sum   <= rx_data;
                            idx   <= '0;
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_done) begin
                        sum <= sum_next;
                        idx <= idx + 1'b1;
                        if (LW'(idx) == len - 1'b1)
                            state <= CSUM;
                    end
                end
                CSUM: begin
                    if (rx_done) begin
                        if (sum_next == 8'd0) begin
                            // Preload the first byte so that out_data is registered and valid immediately.
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_data  <= pay_buf[0];
                            rd        <= '0;
                            out_last  <= (len == LW'(1));
                            frame_len <= len;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                            err_code  <= 2'b10;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rd       <= rd_nxt;
                            out_data <= pay_buf[rd_nxt];
                            out_last <= (LW'(rd_nxt) == len - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // tmr_exp implies no rx_done this cycle, so the case above made no transition.
            if (tmr_exp) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                err_code  <= 2'b11;
            end
        end
    end

`ifdef UART_FRAME_STATS_EN
    logic ok_evt;
    logic bad_evt;

    assign ok_evt  = (state == DRAIN) && out_ready && out_last;
    // An error and a drop in the same cycle count once.
    assign bad_evt = (state == DRAIN && rx_done) || tmr_exp ||
                     (state == LEN  && rx_done && len_bad) ||
                     (state == CSUM && rx_done && sum_next != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok  <= '0;
            stat_bad <= '0;
        end else begin
            if (ok_evt && stat_ok != 16'hFFFF)
                stat_ok <= stat_ok + 1'b1;
            if (bad_evt && stat_bad != 16'hFFFF)
                stat_bad <= stat_bad + 1'b1;
        end
    end
`else
    assign stat_ok  = 16'd0;
    assign stat_bad = 16'd0;
`endif

endmodule
